// File: rtl/sim_run_ctrl.sv
// Run controller for the top-level simulation harness: sequences core reset,
// counts RUN cycles and retired instructions, and ends the run with a single status.
module sim_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned MAX_CYCLES   = 2000000,
  parameter int unsigned HANG_CYCLES  = 10000,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned PC_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             dut_reset,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  input  logic             halt_valid,
  input  logic [31:0]      halt_code,
  output logic             running,
  output logic             done,
  output logic             done_pulse,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [PC_W-1:0]  last_pc
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 32'd1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned IDLE_W = (HANG_CYCLES  > 32'd1) ? $clog2(HANG_CYCLES)  : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 32'd1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HANG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 32'd1);

  localparam logic [2:0] ST_RUNNING = 3'd0;
  localparam logic [2:0] ST_GOOD    = 3'd1;
  localparam logic [2:0] ST_BAD     = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_HANG    = 3'd4;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_dut_reset;
  logic              r_running;
  logic              r_done;
  logic              r_done_pulse;
  logic [2:0]        r_status;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_inst_cnt;
  logic [PC_W-1:0]   r_last_pc;

  logic [CNT_W-1:0]  w_cycle_nxt;
  logic [CNT_W-1:0]  w_inst_nxt;
  logic              w_timeout;
  logic              w_hang;

  // Counters saturate at all-ones so a runaway run never wraps back to small values.
  assign w_cycle_nxt = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1'b1);
  assign w_inst_nxt  = (&r_inst_cnt)  ? r_inst_cnt  : r_inst_cnt  + CNT_W'(1'b1);
  assign w_timeout   = (MAX_CYCLES != 32'd0) && (r_cycle_cnt == CYC_LAST);
  assign w_hang      = (HANG_CYCLES != 32'd0) && !commit_valid && (r_idle_cnt == IDLE_LAST);

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_dut_reset  <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_status     <= ST_RUNNING;
      r_cycle_cnt  <= '0;
      r_inst_cnt   <= '0;
      r_last_pc    <= '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1'b1);
          if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= S_RUN;
            r_dut_reset <= 1'b0;
            r_running   <= 1'b1;
          end else begin
            r_dut_reset <= 1'b1;
            r_running   <= 1'b0;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cycle_nxt;
          if (commit_valid) begin
            r_inst_cnt <= w_inst_nxt;
            r_last_pc  <= commit_pc;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1'b1);
          end
          // Halt outranks timeout, which outranks hang.
          if (halt_valid || w_timeout || w_hang) begin
            r_state      <= S_DONE;
            r_running    <= 1'b0;
            r_done       <= 1'b1;
            r_done_pulse <= 1'b1;
            if (halt_valid) begin
              r_status <= (halt_code == 32'd0) ? ST_GOOD : ST_BAD;
            end else if (w_timeout) begin
              r_status <= ST_TIMEOUT;
            end else begin
              r_status <= ST_HANG;
            end
          end else begin
            r_running <= 1'b1;
          end
        end
        S_DONE: begin
          r_done_pulse <= 1'b0;
        end
        default: begin
          r_state      <= S_HOLD;
          r_hold_cnt   <= '0;
          r_idle_cnt   <= '0;
          r_dut_reset  <= 1'b1;
          r_running    <= 1'b0;
          r_done       <= 1'b0;
          r_done_pulse <= 1'b0;
          r_status     <= ST_RUNNING;
        end
      endcase
    end
  end

  assign dut_reset  = r_dut_reset;
  assign running    = r_running;
  assign done       = r_done;
  assign done_pulse = r_done_pulse;
  assign status     = r_status;
  assign cycle_cnt  = r_cycle_cnt;
  assign inst_cnt   = r_inst_cnt;
  assign last_pc    = r_last_pc;

endmodule
